// File: rtl/serial_paralelo_rx_align_pkg.sv
// Shared symbol constants and FSM encodings for the serial/parallel link blocks.
// The parallel-to-serial idle generator imports the same symbols.
package serial_paralelo_rx_align_pkg;

    localparam logic [7:0] COM_SYMBOL = 8'hBC;
    localparam logic [7:0] IDL_SYMBOL = 8'h7C;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

    // The spare encoding 2'd3 falls back to HUNT so a corrupted state self-recovers.
    function automatic rx_state_t decode_state(input logic [1:0] raw);
        case (raw)
            2'd1:    return SYNC;
            2'd2:    return ACTIVE;
            default: return HUNT;
        endcase
    endfunction

endpackage

// File: rtl/serial_paralelo_rx_align.sv
// Receive-side deserializer: hunts for COM byte alignment, locks after COM_COUNT
// aligned COMs, then emits one byte per 8 clocks with idle symbols filtered out.
//
// state  | meaning
// HUNT   | no alignment; COM searched at every bit offset
// SYNC   | aligned on a COM, counting consecutive aligned COMs
// ACTIVE | link up; data bytes delivered, COM/IDL treated as idle
module serial_paralelo_rx_align
    import serial_paralelo_rx_align_pkg::*;
#(
    parameter int unsigned COM_COUNT = 4,
    parameter logic [7:0]  COM_SYM   = COM_SYMBOL,
    parameter logic [7:0]  IDL_SYM   = IDL_SYMBOL
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam logic [4:0] COM_TARGET = 5'(COM_COUNT);
    localparam bit         SINGLE_COM = (COM_COUNT == 1);

    logic [1:0] state;
    logic [1:0] state_d;
    rx_state_t  cur_state;
    logic [7:0] sr;
    logic [7:0] nxt;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_d;
    logic [3:0] com_cnt;
    logic [3:0] com_cnt_d;
    logic [4:0] com_inc;
    logic       boundary;
    logic       is_com;
    logic       is_idle;
    logic       lock_done;
    logic [7:0] data_out_d;
    logic       valid_d;
    logic       strobe_d;
    logic       active_d;

    assign nxt       = {sr[6:0], data_in};
    assign cur_state = decode_state(state);
    assign boundary  = (bit_cnt == 3'd7);
    assign is_com    = (nxt == COM_SYM);
    assign is_idle   = is_com || (nxt == IDL_SYM);
    assign com_inc   = {1'b0, com_cnt} + 5'd1;
    assign lock_done = (com_inc == COM_TARGET);

    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            state       <= HUNT;
            sr          <= 8'h00;
            bit_cnt     <= 3'd0;
            com_cnt     <= 4'd0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_d;
            sr          <= nxt;
            bit_cnt     <= bit_cnt_d;
            com_cnt     <= com_cnt_d;
            data_out    <= data_out_d;
            valid_out   <= valid_d;
            byte_strobe <= strobe_d;
            active      <= active_d;
        end
    end

    always_comb begin
        state_d   = cur_state;
        bit_cnt_d = bit_cnt + 3'd1;
        com_cnt_d = com_cnt;
        case (cur_state)
            HUNT: begin
                bit_cnt_d = 3'd0;
                if (is_com) begin
                    com_cnt_d = 4'd1;
                    state_d   = SINGLE_COM ? ACTIVE : SYNC;
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (is_com) begin
                        if (com_cnt != 4'hF) begin
                            com_cnt_d = com_inc[3:0];
                        end
                        if (lock_done) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        // Any wrong symbol on a boundary drops all accumulated credit.
                        state_d   = HUNT;
                        com_cnt_d = 4'd0;
                        bit_cnt_d = 3'd0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        data_out_d = data_out;
        valid_d    = 1'b0;
        strobe_d   = 1'b0;
        active_d   = active;
        case (cur_state)
            HUNT: begin
                if (is_com && SINGLE_COM) begin
                    active_d = 1'b1;
                end
            end
            SYNC: begin
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (is_com && lock_done) begin
                        active_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (!is_idle) begin
                        data_out_d = nxt;
                        valid_d    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_paralelo_rx_align.sv
// Directed bench for serial_paralelo_rx_align: reset, alignment, abort, idle
// filtering, mid-byte reset and single-COM lock (second instance, COM_COUNT=1).
module tb_serial_paralelo_rx_align;
    import serial_paralelo_rx_align_pkg::*;

    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;
    logic [7:0] data_out_c1;
    logic       valid_out_c1;
    logic       byte_strobe_c1;
    logic       active_c1;

    int n_cmp = 0;
    int n_bad = 0;

    serial_paralelo_rx_align dut (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .byte_strobe(byte_strobe),
        .active     (active)
    );

    serial_paralelo_rx_align #(.COM_COUNT(1)) dut_c1 (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .data_out   (data_out_c1),
        .valid_out  (valid_out_c1),
        .byte_strobe(byte_strobe_c1),
        .active     (active_c1)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit away from the edge, then return just after the edge that samples it.
    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk_32f);
        reset_L = 1'b0;
        data_in = 1'b0;
        repeat (n) begin
            @(posedge clk_32f);
            #1;
        end
        reset_L = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] com_b;
        logic [4:0] pre;
        int         mid_strobes;
        int         early_active;
        com_b = COM_SYMBOL;
        pre   = 5'b10110;

        // 1: reset held for 3 edges while data_in toggles
        for (int e = 0; e < 3; e++) begin
            @(negedge clk_32f);
            data_in = e[0];
            @(posedge clk_32f);
            #1;
            check($sformatf("t1_outs_e%0d", e), {data_out, valid_out, byte_strobe, active}, 32'h0);
        end
        reset_L = 1'b1;

        // 2: 5 arbitrary bits then 4 aligned COMs
        for (int i = 4; i >= 0; i--) begin
            send_bit(pre[i]);
            if (i == 4) check("t1_state_hunt", 32'(dut.state), 32'(HUNT));
        end
        send_byte(com_b);
        check("t2_strobe_bc1", byte_strobe, 1'b0);
        check("t2_active_bc1", active, 1'b0);
        mid_strobes  = 0;
        early_active = 0;
        for (int k = 2; k <= 4; k++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(com_b[i]);
                if (i != 0 && byte_strobe) mid_strobes++;
                if (i != 0 && active) early_active++;
            end
            check($sformatf("t2_strobe_bc%0d", k), byte_strobe, 1'b1);
            check($sformatf("t2_active_bc%0d", k), active, k == 4);
        end
        check("t2_mid_strobes", mid_strobes, 0);
        check("t2_early_active", early_active, 0);

        // 3: 3 COMs, a bad byte, then 4 fresh COMs
        apply_reset(2);
        repeat (3) send_byte(com_b);
        check("t3_active_3bc", active, 1'b0);
        send_byte(8'h00);
        check("t3_active_00", active, 1'b0);
        check("t3_state_00", 32'(dut.state), 32'(HUNT));
        for (int k = 1; k <= 4; k++) begin
            send_byte(com_b);
            check($sformatf("t3_active_bc%0d", k), active, k == 4);
        end

        // 4: idle filtering in ACTIVE
        send_byte(8'h7C);
        check("t4_valid_7c", valid_out, 1'b0);
        check("t4_data_7c", data_out, 8'h00);
        send_byte(8'hA5);
        check("t4_valid_a5", valid_out, 1'b1);
        check("t4_data_a5", data_out, 8'hA5);
        send_bit(com_b[7]);
        check("t4_valid_pulse", valid_out, 1'b0);
        for (int i = 6; i >= 0; i--) send_bit(com_b[i]);
        check("t4_valid_bc", valid_out, 1'b0);
        check("t4_hold_bc", data_out, 8'hA5);
        send_byte(8'h3C);
        check("t4_valid_3c", valid_out, 1'b1);
        check("t4_data_3c", data_out, 8'h3C);

        // 5: reset mid-byte while ACTIVE, then realign
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        apply_reset(1);
        check("t5_active", active, 1'b0);
        check("t5_valid", valid_out, 1'b0);
        check("t5_data", data_out, 8'h00);
        for (int k = 1; k <= 4; k++) begin
            send_byte(com_b);
            check($sformatf("t5_active_bc%0d", k), active, k == 4);
        end

        // 6: single-COM build locks on one COM at an odd offset
        apply_reset(2);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_byte(com_b);
        check("t6_active_c1", active_c1, 1'b1);
        check("t6_strobe_c1_bc", byte_strobe_c1, 1'b0);
        check("t6_valid_c1_bc", valid_out_c1, 1'b0);
        check("t6_active_c4", active, 1'b0);
        send_byte(8'h11);
        check("t6_valid_c1_11", valid_out_c1, 1'b1);
        check("t6_data_c1_11", data_out_c1, 8'h11);
        check("t6_strobe_c1_11", byte_strobe_c1, 1'b1);
        send_bit(1'b0);
        check("t6_valid_c1_pulse", valid_out_c1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
